// File: rtl/bus_xfer_sequencer.sv
// Round-robin sequencer for register-to-register moves over a shared tri-state bus.
// Each transfer drives one OE_bar low, strobes LD once the bus has settled, then releases the bus for a dead cycle.
module bus_xfer_sequencer #(
    parameter int NREQ   = 4,
    parameter int NREG   = 8,
    parameter int SELW   = 3,
    parameter int SETTLE = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ*SELW-1:0] SRC_SEL,
    input  logic [NREQ*SELW-1:0] DST_SEL,
    output logic [NREQ-1:0]      GNT,
    output logic [NREQ-1:0]      DONE,
    output logic                 ERR,
    output logic [NREG-1:0]      OE_bar,
    output logic [NREG-1:0]      LD,
    output logic                 BUSY,
    output logic [1:0]           STATE_DBG
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_LATCH, S_RELEASE} state_t;

    state_t          state, state_d;
    logic [PW-1:0]   ptr, ptr_d, win_idx, cand;
    logic            win_found, reject;
    logic [SELW-1:0] src_q, dst_q, src_d, dst_d, req_src, req_dst;
    logic [NREQ-1:0] win_q, win_d;
    logic [3:0]      cnt, cnt_d;
    logic [NREQ-1:0] gnt_d, done_d;
    logic            err_d, busy_d;
    logic [NREG-1:0] oe_d, ld_d;

    // Search starts just after the last winner, so the previous winner ranks last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PW'((int'(ptr) + i) % NREQ);
            if (!win_found && REQ[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        req_src = '0;
        req_dst = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (win_idx == PW'(r)) begin
                req_src = SRC_SEL[r*SELW +: SELW];
                req_dst = DST_SEL[r*SELW +: SELW];
            end
        end
        reject = (req_src == req_dst) || (int'(req_src) >= NREG) || (int'(req_dst) >= NREG);
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cnt_d   = cnt;
        src_d   = src_q;
        dst_d   = dst_q;
        win_d   = win_q;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    ptr_d = win_idx;
                    win_d = NREQ'(1) << win_idx;
                    src_d = req_src;
                    dst_d = req_dst;
                    if (!reject) begin
                        state_d = S_DRIVE;
                        cnt_d   = 4'(SETTLE);
                    end
                end
            end
            S_DRIVE: begin
                cnt_d = cnt - 4'd1;
                if (cnt <= 4'd1) state_d = S_LATCH;
            end
            S_LATCH: state_d = S_RELEASE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so the bus pins never glitch.
    always_comb begin
        gnt_d  = '0;
        done_d = '0;
        err_d  = 1'b0;
        oe_d   = '1;
        ld_d   = '0;
        busy_d = (state_d != S_IDLE);
        if (state == S_IDLE && win_found && reject) begin
            err_d  = 1'b1;
            done_d = win_d;
        end
        if (state_d == S_DRIVE || state_d == S_LATCH) begin
            gnt_d = win_d;
            for (int r = 0; r < NREG; r++) begin
                if (SELW'(r) == src_d) oe_d[r] = 1'b0;
            end
        end
        if (state_d == S_LATCH) begin
            for (int r = 0; r < NREG; r++) begin
                if (SELW'(r) == dst_d) ld_d[r] = 1'b1;
            end
        end
        if (state_d == S_RELEASE) done_d = win_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            ptr    <= PW'(NREQ - 1);
            cnt    <= '0;
            src_q  <= '0;
            dst_q  <= '0;
            win_q  <= '0;
            GNT    <= '0;
            DONE   <= '0;
            ERR    <= 1'b0;
            OE_bar <= '1;
            LD     <= '0;
            BUSY   <= 1'b0;
        end else begin
            state  <= state_d;
            ptr    <= ptr_d;
            cnt    <= cnt_d;
            src_q  <= src_d;
            dst_q  <= dst_d;
            win_q  <= win_d;
            GNT    <= gnt_d;
            DONE   <= done_d;
            ERR    <= err_d;
            OE_bar <= oe_d;
            LD     <= ld_d;
            BUSY   <= busy_d;
        end
    end

    assign STATE_DBG = state;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Bench for bus_xfer_sequencer: two instances (SETTLE=1 and SETTLE=3) share stimulus and are
// compared cycle by cycle against a transfer-level model that emits whole expected waveforms per grant.
module tb_bus_xfer_sequencer;
    localparam int NREQ = 4;
    localparam int NREG = 8;
    localparam int SELW = 3;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic [NREQ-1:0]      REQ = '0;
    logic [NREQ*SELW-1:0] SRC_SEL = '0;
    logic [NREQ*SELW-1:0] DST_SEL = '0;

    logic [NREQ-1:0] gnt_a, done_a, gnt_b, done_b;
    logic            err_a, err_b, busy_a, busy_b;
    logic [NREG-1:0] oe_a, ld_a, oe_b, ld_b;
    logic [1:0]      st_a, st_b;

    int n_checks = 0;
    int n_errors = 0;
    bit checking = 1'b0;

    // Frame layout: {gnt[3:0], done[3:0], err, oe_bar[7:0], ld[7:0], busy}
    logic [25:0] exp_q0[$];
    logic [25:0] exp_q1[$];
    int          ptr_m[2];

    always #5 CLK = ~CLK;

    bus_xfer_sequencer #(.NREQ(NREQ), .NREG(NREG), .SELW(SELW), .SETTLE(1)) dut_a (
        .CLK(CLK), .RST(RST), .REQ(REQ), .SRC_SEL(SRC_SEL), .DST_SEL(DST_SEL),
        .GNT(gnt_a), .DONE(done_a), .ERR(err_a), .OE_bar(oe_a), .LD(ld_a),
        .BUSY(busy_a), .STATE_DBG(st_a)
    );

    bus_xfer_sequencer #(.NREQ(NREQ), .NREG(NREG), .SELW(SELW), .SETTLE(3)) dut_b (
        .CLK(CLK), .RST(RST), .REQ(REQ), .SRC_SEL(SRC_SEL), .DST_SEL(DST_SEL),
        .GNT(gnt_b), .DONE(done_b), .ERR(err_b), .OE_bar(oe_b), .LD(ld_b),
        .BUSY(busy_b), .STATE_DBG(st_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [25:0] frame(input logic [3:0] g, input logic [3:0] d, input logic e,
                                          input logic [7:0] oe, input logic [7:0] ld, input logic b);
        return {g, d, e, oe, ld, b};
    endfunction

    function automatic logic [25:0] idle_frame();
        return frame(4'h0, 4'h0, 1'b0, 8'hFF, 8'h00, 1'b0);
    endfunction

    task automatic push(input int m, input logic [25:0] f);
        if (m == 0) exp_q0.push_back(f);
        else        exp_q1.push_back(f);
    endtask

    // Transfer-level model: one grant expands into its full expected waveform.
    task automatic model_arb(input int m, input int settle);
        int w, s, d;
        logic [3:0] oh;
        logic [7:0] oe_f, ld_f;
        w = -1;
        for (int i = 1; i <= NREQ; i++) begin
            int k;
            k = (ptr_m[m] + i) % NREQ;
            if (w < 0 && ((REQ >> k) & 4'b0001) != 4'b0000) w = k;
        end
        if (w >= 0) begin
            ptr_m[m] = w;
            s  = int'((SRC_SEL >> (w * SELW)) & 12'h007);
            d  = int'((DST_SEL >> (w * SELW)) & 12'h007);
            oh = 4'(1 << w);
            if (s == d || s >= NREG || d >= NREG) begin
                push(m, frame(4'h0, oh, 1'b1, 8'hFF, 8'h00, 1'b0));
            end else begin
                oe_f = ~8'(1 << s);
                ld_f = 8'(1 << d);
                repeat (settle) push(m, frame(oh, 4'h0, 1'b0, oe_f, 8'h00, 1'b1));
                push(m, frame(oh, 4'h0, 1'b0, oe_f, ld_f, 1'b1));
                push(m, frame(4'h0, oh, 1'b0, 8'hFF, 8'h00, 1'b1));
                push(m, idle_frame());
            end
        end
    endtask

    task automatic compare(input int m, input logic [25:0] act, input logic [25:0] ex);
        string p;
        p = (m == 0) ? "s1" : "s3";
        check($sformatf("%s.gnt", p),  32'(act[25:22]), 32'(ex[25:22]));
        check($sformatf("%s.done", p), 32'(act[21:18]), 32'(ex[21:18]));
        check($sformatf("%s.err", p),  32'(act[17]),    32'(ex[17]));
        check($sformatf("%s.oe_bar", p), 32'(act[16:9]), 32'(ex[16:9]));
        check($sformatf("%s.ld", p),   32'(act[8:1]),   32'(ex[8:1]));
        check($sformatf("%s.busy", p), 32'(act[0]),     32'(ex[0]));
        check($sformatf("%s.inv_one_driver", p), 32'($countones(~act[16:9]) <= 1), 32'd1);
        check($sformatf("%s.inv_one_load", p),   32'($countones(act[8:1]) <= 1),   32'd1);
        check($sformatf("%s.inv_ld_with_oe", p), 32'(act[8:1] == 8'h00 || act[16:9] != 8'hFF), 32'd1);
    endtask

    task automatic step();
        logic [25:0] act, ex;
        @(negedge CLK);
        for (int m = 0; m < 2; m++) begin
            act = (m == 0) ? {gnt_a, done_a, err_a, oe_a, ld_a, busy_a}
                           : {gnt_b, done_b, err_b, oe_b, ld_b, busy_b};
            ex = idle_frame();
            if (m == 0 && exp_q0.size() > 0) ex = exp_q0.pop_front();
            if (m == 1 && exp_q1.size() > 0) ex = exp_q1.pop_front();
            if (checking) compare(m, act, ex);
            if (RST) begin
                if (m == 0) exp_q0.delete();
                else        exp_q1.delete();
                ptr_m[m] = NREQ - 1;
            end else if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
                model_arb(m, (m == 0) ? 1 : 3);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic set_pair(input int r, input int s, input int d);
        SRC_SEL[r*SELW +: SELW] = 3'(s);
        DST_SEL[r*SELW +: SELW] = 3'(d);
    endtask

    task automatic drain();
        REQ = '0;
        repeat (10) step();
    endtask

    initial begin
        ptr_m[0] = NREQ - 1;
        ptr_m[1] = NREQ - 1;
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        checking = 1'b1;
        step();

        // Single transfer from requester 0, src 2 -> dst 5.
        set_pair(0, 2, 5);
        REQ = 4'b0001;
        step();
        drain();

        // Full load with distinct pairs.
        set_pair(0, 0, 1);
        set_pair(1, 2, 3);
        set_pair(2, 4, 5);
        set_pair(3, 6, 7);
        REQ = 4'b1111;
        repeat (24) step();
        drain();

        // src 7 -> dst 0, longest settle visible on the SETTLE=3 instance.
        set_pair(2, 7, 0);
        REQ = 4'b0100;
        step();
        drain();

        // Rejected pair, then a valid one from the same requester.
        set_pair(1, 4, 4);
        REQ = 4'b0010;
        step();
        set_pair(1, 3, 1);
        step();
        drain();

        // Reset while the SETTLE=1 instance is in LATCH.
        set_pair(0, 1, 6);
        REQ = 4'b0001;
        step();
        REQ = 4'b0000;
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        drain();

        // Selects scrambled and request dropped after capture.
        set_pair(2, 3, 6);
        REQ = 4'b0100;
        step();
        set_pair(2, 5, 5);
        REQ = 4'b0000;
        step();
        set_pair(2, 0, 7);
        drain();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 3) == 0) REQ = 4'($urandom_range(0, 15));
            for (int r = 0; r < NREQ; r++) begin
                if ($urandom_range(0, 2) == 0) set_pair(r, $urandom_range(0, 7), $urandom_range(0, 7));
            end
            RST = ($urandom_range(0, 63) == 0);
            step();
            RST = 1'b0;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_xfer_sequencer.md
Name: bus_xfer_sequencer

Overview:
- Sequences register-to-register transfers over a shared tri-state data bus built from octal D-FF registers with active-low output enables (OE_bar).
- Up to NREQ requesters each post a source/destination register pair.
- The block arbitrates round-robin among requesters, then drives exactly one OE_bar low, pulses the destination load strobe once the bus has settled, and releases the bus with a dead cycle. This guarantees no two registers ever drive the bus at once.
- Sits between the microcode/control logic and the register bank.

Parameters:
- NREQ, 4, number of requesters.
- NREG, 8, number of bus registers (OE_bar / LD lines).
- SELW, 3, register select width; must satisfy 2**SELW >= NREG.
- SETTLE, 1, cycles spent in DRIVE before latching; legal range 1..15.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous reset, active-high.
- REQ  in  NREQ  per-requester transfer request; level, held until DONE.
- SRC_SEL  in  NREQ*SELW  source register index; requester i uses bits [i*SELW +: SELW].
- DST_SEL  in  NREQ*SELW  destination register index, same packing.
- GNT  out  NREQ  one-hot grant, high from DRIVE through LATCH.
- DONE  out  NREQ  one-cycle completion pulse to the winner.
- ERR  out  1  one-cycle pulse on a rejected request.
- OE_bar  out  NREG  active-low output enables to the registers; at most one low.
- LD  out  NREG  load enable, used to gate register clocks; at most one high.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RST high at edge): state=IDLE; OE_bar all 1; LD, GNT, DONE, ERR, BUSY all 0; RR pointer=NREQ-1, so requester 0 is first priority. RST overrides everything, including mid-transfer: the bus is released on the same edge.
- States: IDLE, DRIVE, LATCH, RELEASE. All outputs are registered.
- IDLE:
  - If any REQ is high, pick the winner w: the first requester with REQ high, searching from pointer+1 and wrapping modulo NREQ.
  - Capture src/dst for w and set pointer=w.
  - Reject if src==dst, src>=NREG, or dst>=NREG: pulse ERR and DONE[w] next cycle, stay in IDLE, outputs unchanged.
  - Otherwise go to DRIVE with GNT[w]=1, OE_bar[src]=0, counter=SETTLE.
- DRIVE: decrement counter each cycle. When counter==1 at the edge, go to LATCH. OE_bar and GNT are held.
- LATCH: exactly one cycle with LD[dst]=1; OE_bar[src] stays 0.
- RELEASE: OE_bar all 1, LD=0, GNT=0, DONE[w]=1 for one cycle, then IDLE.
- Latency (SETTLE=1): request seen at edge 0 -> DRIVE cycle 1 -> LATCH cycle 2 -> RELEASE/DONE cycle 3 -> IDLE cycle 4, which may grant again. One transfer per 4 cycles at full load; generally 3+SETTLE.
- Captured src/dst are frozen for the whole transfer. Changes on SEL inputs, or REQ dropping, after capture are ignored and the transfer completes.
- After DONE, the requester must drop REQ or present a new pair. REQ still high in IDLE is treated as a new request.
- Invariants, checked every cycle:
  - popcount(~OE_bar) <= 1.
  - popcount(LD) <= 1.
  - LD high only while OE_bar is low.
  - OE_bar is all 1 for at least one cycle between any two transfers.
- Round-robin: a requester that just won has lowest priority next. No starvation; worst-case wait is NREQ-1 transfers.

Test Plan:
- Reset, then REQ=0001, src=2, dst=5, SETTLE=1:
  - cycle 1: GNT=0001, OE_bar=11111011.
  - cycle 2: LD=00100000.
  - cycle 3: OE_bar=FF, DONE=0001.
  - cycle 4: IDLE, BUSY=0.
- REQ=1111 held continuously, every requester with distinct valid pairs -> grant order 0,1,2,3,0,…; one DONE every 4 cycles; OE_bar all 1 in every RELEASE cycle.
- SETTLE=3, src=7, dst=0 -> OE_bar[7] low for 4 cycles (3 DRIVE + LATCH); LD[0] high exactly on the 4th of those cycles.
- Requester 1 with src=dst=4 -> ERR and DONE=0010 pulse one cycle; OE_bar and LD never change; next request is served normally.
- RST asserted during LATCH (src=1, dst=6) -> next cycle OE_bar=FF, LD=0, GNT=0, state IDLE; no DONE issued.
- SRC_SEL/DST_SEL changed and REQ dropped during DRIVE -> original src/dst are used to completion and DONE still pulses.
